clk_div_scheduler: RTL and testbench
====================================

Name: clk_div_scheduler

Overview:
Run-time controller for the team's clock-divider datapath. It owns a programmable divide counter and generates the divided clock level plus a period tick. It arbitrates divide-ratio update requests from NREQ requesters (round-robin). Accepted ratios are applied only at a period boundary, so div_out never shows a runt pulse. Start and stop requests also take effect at a period boundary.

Parameters:
NREQ, 2, number of update requesters (1..8)
W, 8, divide-ratio width in bits
DEFAULT_DIV, 8, divide ratio loaded by reset (must be >= 2)

Ports:
clk  input  1  system clock; all logic on posedge clk
clr  input  1  synchronous reset, active-high
enable  input  1  run request for the divider
req  input  NREQ  per-requester update request; level, held until ack
div_in  input  NREQ*W  requested ratio; slice i = div_in[i*W +: W]
ack  output  NREQ  one-cycle grant pulse, one-hot or zero
err  output  1  one-cycle pulse with ack when the granted ratio is illegal (<2)
busy  output  1  an accepted ratio is waiting for the period boundary
running  output  1  divider is in RUN or STOPPING
cur_div  output  W  ratio currently in effect
div_out  output  1  divided clock level, registered
tick  output  1  one-cycle pulse in cycle k=0 of every period

Behaviour:
- Reset (clr=1 at posedge): state=IDLE, cnt=0, cur_div=DEFAULT_DIV, shadow=0, busy=0, ack=0, err=0, div_out=0, tick=0, running=0, rr_ptr=0. Reset has priority over every other event. Reset mid-period drops div_out to 0 on the next cycle.
- States:
  - IDLE: cnt held at 0; div_out=0.
  - RUN: counting.
  - STOPPING: counting; the current period finishes, then the block goes to IDLE.
- IDLE -> RUN: when enable=1.
  - Period 0, cycle k=0 appears on the registered outputs 1 cycle after enable is sampled high.
- RUN:
  - cnt counts 0..D-1 and wraps, with D=cur_div.
  - In cycle k: div_out=1 for k < ceil(D/2), else 0; tick=1 only at k=0.
  - Odd D gives a high phase that is one cycle longer than the low phase.
- RUN -> STOPPING: when enable=0 is sampled.
- STOPPING -> RUN: if enable=1 is sampled before the period ends, with no disturbance to the period.
- STOPPING -> IDLE: in the cycle after k=D-1, if enable is still 0.
- Arbitration:
  - Evaluated only when busy=0 at the start of the cycle.
  - Search starts at rr_ptr and takes the first asserted req.
  - Winner i: ack[i]=1 for one cycle, and rr_ptr=(i+1) mod NREQ.
  - If div_in[i] >= 2: shadow=div_in[i], busy=1.
  - If div_in[i] < 2: err=1 together with ack, the request is discarded, busy stays 0.
  - No grant while busy=1.
  - A requester must drop req in the cycle after ack. A req still high then counts as a new request.
- Apply rules:
  - In RUN/STOPPING, busy=1 and k=D-1: cur_div=shadow and busy=0. The next period uses the new D from k=0.
  - In IDLE, busy=1: apply in the next cycle.
- Boundary apply and a new req in the same cycle: the grant comes 1 cycle later, because busy was 1 at the start of the apply cycle.
- Grant and apply in the same cycle are impossible by construction.
- cur_div changes only at the apply point, never mid-period.
- Width rules:
  - cnt is W bits.
  - ceil(D/2) is computed as (D+1)>>1 in W+1 bits so there is no overflow at D=2^W-1.

Test Plan:
- Reset, enable=1, no requests -> from the cycle after enable: div_out 1111_0000 repeating (D=8), tick every 8 cycles at the start of the high phase; cur_div=8.
- Requester 0 asks for 5 mid-period (k=2) -> ack[0] 1 cycle later, busy=1 until k=7; next periods are 11100 with tick every 5 cycles; cur_div=5 exactly at the boundary.
- req=2'b11, ratios 4 and 6, both held -> ack[0] first, ack[1] only after the D=4 apply clears busy; final cur_div=6; rr_ptr alternates on the next tie.
- Request with div_in=1 -> ack with err=1, busy stays 0, cur_div and waveform unchanged.
- enable drops at k=1 of a D=8 period -> period completes (8 cycles total), then div_out=0 and running=0; enable reasserted at k=5 instead -> continuous output, no gap.
- clr=1 at k=2 of a D=5 period with busy=1 -> next cycle: div_out=0, busy=0, cur_div=8, state IDLE; pending ratio discarded.

Source files
------------

// File: rtl/clk_div_scheduler.sv
// clk_div_scheduler: programmable clock divider with round-robin ratio updates.
// New ratios are held in a shadow register and applied only at a period
// boundary (or at once when idle), so div_out never shows a runt pulse.
module clk_div_scheduler #(
    parameter int NREQ        = 2,
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] div_in,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              busy,
    output logic              running,
    output logic [W-1:0]      cur_div,
    output logic              div_out,
    output logic              tick
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t        state;
    logic [W-1:0]  cnt;
    logic [W-1:0]  shadow;
    logic [PW-1:0] rr_ptr;

    logic          gnt_vld;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] ptr_next;
    logic [W-1:0]  gnt_div;
    logic [NREQ-1:0] gnt_oh;
    int            cand;

    logic          last;
    logic [W-1:0]  k_next;
    logic [W:0]    half;
    logic          hi_next;

    // Round-robin search starting at rr_ptr; first asserted req wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int j = 0; j < NREQ; j++) begin
            cand = int'(rr_ptr) + j;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(cand);
            end
        end
    end

    assign gnt_div  = div_in[int'(gnt_idx)*W +: W];
    assign gnt_oh   = NREQ'(1) << gnt_idx;
    assign ptr_next = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

    // Counter look-ahead: outputs are registered alongside cnt, so they are
    // computed from the next count. Half-period is done in W+1 bits so that
    // D = 2^W-1 does not overflow.
    assign last    = (cnt == cur_div - 1'b1);
    assign k_next  = last ? '0 : cnt + 1'b1;
    assign half    = ({1'b0, cur_div} + 1'b1) >> 1;
    assign hi_next = ({1'b0, k_next} < half);

    // Control FSM, arbiter grant, shadow apply and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_div <= W'(DEFAULT_DIV);
            shadow  <= '0;
            busy    <= 1'b0;
            ack     <= '0;
            err     <= 1'b0;
            div_out <= 1'b0;
            tick    <= 1'b0;
            running <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;

            // Grants only when nothing is pending, so grant and apply never
            // land in the same cycle.
            if (!busy && gnt_vld) begin
                ack    <= gnt_oh;
                rr_ptr <= ptr_next;
                if (gnt_div >= W'(2)) begin
                    shadow <= gnt_div;
                    busy   <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    div_out <= 1'b0;
                    tick    <= 1'b0;
                    // No period in flight, so a pending ratio applies at once.
                    if (busy) begin
                        cur_div <= shadow;
                        busy    <= 1'b0;
                    end
                    if (enable) begin
                        state   <= RUN;
                        running <= 1'b1;
                        div_out <= 1'b1;
                        tick    <= 1'b1;
                    end
                end
                RUN, STOPPING: begin
                    cnt     <= k_next;
                    div_out <= hi_next;
                    tick    <= last;
                    if (last && busy) begin
                        cur_div <= shadow;
                        busy    <= 1'b0;
                    end
                    if (state == RUN) begin
                        if (!enable) state <= STOPPING;
                    end else if (enable) begin
                        state <= RUN;
                    end else if (last) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        cnt     <= '0;
                        div_out <= 1'b0;
                        tick    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Directed bench for clk_div_scheduler (NREQ=2, W=8, DEFAULT_DIV=8).
module tb_clk_div_scheduler;

    logic        clk = 1'b0;
    logic        clr;
    logic        enable;
    logic [1:0]  req;
    logic [15:0] div_in;
    logic [1:0]  ack;
    logic        err, busy, running, div_out, tick;
    logic [7:0]  cur_div;

    int n_chk  = 0;
    int n_pass = 0;

    clk_div_scheduler #(.NREQ(2), .W(8), .DEFAULT_DIV(8)) dut (
        .clk(clk), .clr(clr), .enable(enable), .req(req), .div_in(div_in),
        .ack(ack), .err(err), .busy(busy), .running(running),
        .cur_div(cur_div), .div_out(div_out), .tick(tick)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Check n cycles of the waveform for divide ratio d, starting at cycle k0.
    task automatic run_chk(input int d, input int k0, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = (k0 + i) % d;
            chk($sformatf("div_out D=%0d k=%0d", d, k), div_out, k < (d + 1) / 2);
            chk($sformatf("tick D=%0d k=%0d", d, k), tick, k == 0);
            cyc();
        end
    endtask

    initial begin
        clr = 1'b1; enable = 1'b0; req = 2'b00; div_in = '0;
        cyc(); cyc();
        chk("rst div_out", div_out, 0);
        chk("rst tick", tick, 0);
        chk("rst busy", busy, 0);
        chk("rst running", running, 0);
        chk("rst cur_div", cur_div, 8);
        chk("rst ack", ack, 0);
        chk("rst err", err, 0);
        clr = 1'b0;
        cyc();
        chk("idle running", running, 0);
        chk("idle div_out", div_out, 0);

        // Start with default ratio 8.
        enable = 1'b1;
        cyc();
        chk("start running", running, 1);
        chk("start cur_div", cur_div, 8);
        run_chk(8, 0, 16);

        // Requester 0 asks for 5 at k=2.
        cyc(); cyc();
        req = 2'b01; div_in[7:0] = 8'd5;
        cyc();
        chk("d5 ack", ack, 2'b01);
        chk("d5 busy", busy, 1);
        chk("d5 err", err, 0);
        chk("d5 cur_div hold", cur_div, 8);
        req = 2'b00;
        run_chk(8, 3, 1);
        chk("d5 ack drop", ack, 0);
        chk("d5 busy k4", busy, 1);
        run_chk(8, 4, 3);
        chk("d5 busy k7", busy, 1);
        chk("d5 cur_div k7", cur_div, 8);
        chk("d5 div_out k7", div_out, 0);
        cyc();
        chk("d5 applied busy", busy, 0);
        chk("d5 applied cur_div", cur_div, 5);
        run_chk(5, 0, 10);

        // Illegal ratio from requester 1.
        req = 2'b10; div_in[15:8] = 8'd1;
        cyc();
        chk("bad ack", ack, 2'b10);
        chk("bad err", err, 1);
        chk("bad busy", busy, 0);
        req = 2'b00;
        cyc();
        chk("bad ack drop", ack, 0);
        chk("bad err drop", err, 0);
        chk("bad busy after", busy, 0);
        chk("bad cur_div", cur_div, 5);
        run_chk(5, 2, 3);

        // Tie: 0 asks 4, 1 asks 6, both held.
        req = 2'b11; div_in = {8'd6, 8'd4};
        cyc();
        chk("tie ack0", ack, 2'b01);
        chk("tie busy0", busy, 1);
        req = 2'b10;
        run_chk(5, 1, 3);
        chk("tie busy k4", busy, 1);
        chk("tie no ack while busy", ack, 0);
        chk("tie cur_div k4", cur_div, 5);
        cyc();
        chk("tie d4 cur_div", cur_div, 4);
        chk("tie d4 busy", busy, 0);
        chk("tie d4 ack", ack, 0);
        chk("tie d4 tick", tick, 1);
        cyc();
        chk("tie ack1", ack, 2'b10);
        chk("tie busy1", busy, 1);
        req = 2'b00;
        run_chk(4, 1, 3);
        chk("tie d6 cur_div", cur_div, 6);
        chk("tie d6 busy", busy, 0);
        run_chk(6, 0, 12);

        // Round-robin alternation on consecutive ties.
        req = 2'b11; div_in = {8'd6, 8'd6};
        cyc();
        chk("rr tie1 ack", ack, 2'b01);
        req = 2'b00;
        repeat (5) cyc();
        chk("rr tie1 busy", busy, 0);
        chk("rr tie1 cur_div", cur_div, 6);
        req = 2'b11;
        cyc();
        chk("rr tie2 ack", ack, 2'b10);
        req = 2'b00;
        repeat (5) cyc();

        // Back to ratio 8 through requester 0.
        req = 2'b01; div_in[7:0] = 8'd8;
        cyc();
        chk("d8 ack", ack, 2'b01);
        req = 2'b00;
        repeat (5) cyc();
        chk("d8 cur_div", cur_div, 8);

        // Stop at k=1: the period still completes.
        cyc();
        enable = 1'b0;
        run_chk(8, 1, 7);
        chk("stop div_out", div_out, 0);
        chk("stop running", running, 0);
        chk("stop tick", tick, 0);
        cyc();
        chk("stopped div_out", div_out, 0);
        chk("stopped running", running, 0);

        // Restart, drop at k=1, reassert at k=5: no gap.
        enable = 1'b1;
        cyc();
        chk("restart tick", tick, 1);
        chk("restart running", running, 1);
        cyc();
        enable = 1'b0;
        cyc();
        chk("stopping running", running, 1);
        run_chk(8, 2, 3);
        enable = 1'b1;
        run_chk(8, 5, 11);
        chk("resume running", running, 1);

        // Reset in the middle of a D=5 period with a ratio pending.
        req = 2'b10; div_in[15:8] = 8'd5;
        cyc();
        chk("pre-clr ack", ack, 2'b10);
        req = 2'b00;
        repeat (7) cyc();
        chk("pre-clr cur_div", cur_div, 5);
        req = 2'b01; div_in[7:0] = 8'd7;
        cyc();
        chk("pend ack", ack, 2'b01);
        chk("pend busy", busy, 1);
        req = 2'b00;
        cyc();
        chk("pend busy k2", busy, 1);
        chk("pend cur_div k2", cur_div, 5);
        clr = 1'b1;
        cyc();
        chk("clr div_out", div_out, 0);
        chk("clr busy", busy, 0);
        chk("clr cur_div", cur_div, 8);
        chk("clr running", running, 0);
        chk("clr tick", tick, 0);
        chk("clr ack", ack, 0);
        clr = 1'b0;
        cyc();
        chk("post-clr cur_div", cur_div, 8);
        run_chk(8, 0, 8);
        chk("post-clr cur_div end", cur_div, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
